frs_queueing_ext_cap: RTL and testbench

- Full PCIe FRS Queueing Extended Capability (cap ID 0x0021, 4 DWORDs) for a Root Port / RCEC.
- Holds a parametrised-depth FIFO of received FRS Messages (Requester ID + FRS Reason), RW1C status bits, an interrupt-enable control bit, and a dequeue-on-write queue register.
- Generates a one-cycle interrupt request pulse toward the MSI/MSI-X engine.
- Sits behind the config-space decoder; FRS messages arrive from the message-decode stage.

---
 rtl/frs_queueing_ext_cap.sv | 152 +++++++++++++++
 tb/tb_frs_queueing_ext_cap.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frs_queueing_ext_cap.sv
// PCIe FRS Queueing Extended Capability: FIFO of received FRS messages, RW1C status and interrupt pulse.
// Optional occupancy high-watermark tracking is enabled by defining FRS_QUEUE_HWM_EN.
module frs_queueing_ext_cap #(
  parameter int          QUEUE_DEPTH  = 8,
  parameter logic [3:0]  CAP_VERSION  = 4'h1,
  parameter logic [11:0] NEXT_CAP_PTR = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  input  logic [1:0]  cfg_dw,
  input  logic [3:0]  cfg_be,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        cfg_rd_valid,
  input  logic [4:0]  int_msg_num,
  input  logic        frs_msg_valid,
  input  logic [15:0] frs_msg_rid,
  input  logic [3:0]  frs_msg_reason,
  output logic        irq_req,
  output logic [11:0] queue_count,
  output logic [11:0] queue_hwm
);

  localparam int              PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [11:0]     DEPTH12  = 12'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);

  logic [19:0]      mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [11:0]      count_reg, count_next;
  logic             received_reg, received_next;
  logic             overflow_reg, overflow_next;
  logic             int_en_reg, int_en_next;
  logic             pend_reg, pend_next;
  logic             irq_req_reg;
  logic [31:0]      rdata_reg, rdata_next;
  logic             rd_valid_reg;
  logic [11:0]      hwm_reg;

  logic wr_dw2, pop_req, pop_ok, push_ok, clr_received, clr_overflow;
  logic [31:0] head_data;

  assign wr_dw2       = cfg_wr && (cfg_dw == 2'd2);
  assign pop_req      = cfg_wr && (cfg_dw == 2'd3) && (cfg_be != 4'h0);
  assign pop_ok       = pop_req && (count_reg != 12'd0);
  // A pop in the same cycle frees a slot, so a full queue still accepts the push.
  assign push_ok      = frs_msg_valid && ((count_reg < DEPTH12) || pop_ok);
  assign clr_received = wr_dw2 && cfg_be[0] && cfg_wdata[0];
  assign clr_overflow = wr_dw2 && cfg_be[0] && cfg_wdata[1];

  assign head_data = (count_reg == 12'd0) ? 32'h0 : {12'h000, mem[rd_ptr_reg]};

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (push_ok) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 12'd1;
      2'b01:   count_next = count_reg - 12'd1;
      default: count_next = count_reg;
    endcase
  end

  // Hardware set wins over a software clear landing in the same cycle.
  always_comb begin
    received_next = (received_reg & ~clr_received) | push_ok;
    overflow_next = (overflow_reg & ~clr_overflow) | (frs_msg_valid & ~push_ok);
    int_en_next   = (wr_dw2 && cfg_be[2]) ? cfg_wdata[16] : int_en_reg;
    pend_next     = int_en_next & (received_next | overflow_next);
  end

  always_comb begin
    rdata_next = rdata_reg;
    if (cfg_rd) begin
      case (cfg_dw)
        2'd0:    rdata_next = {NEXT_CAP_PTR, CAP_VERSION, 16'h0021};
        2'd1:    rdata_next = {11'h000, int_msg_num, 4'h0, DEPTH12};
        2'd2:    rdata_next = {15'h0000, int_en_reg, 14'h0000, overflow_reg, received_reg};
        default: rdata_next = head_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      received_reg <= 1'b0;
      overflow_reg <= 1'b0;
      int_en_reg   <= 1'b0;
      pend_reg     <= 1'b0;
      irq_req_reg  <= 1'b0;
      rdata_reg    <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      received_reg <= received_next;
      overflow_reg <= overflow_next;
      int_en_reg   <= int_en_next;
      pend_reg     <= pend_next;
      irq_req_reg  <= pend_next & ~pend_reg;
      rdata_reg    <= rdata_next;
      rd_valid_reg <= cfg_rd;
    end
  end

  // Entry storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= {frs_msg_reason, frs_msg_rid};
    end
  end

`ifdef FRS_QUEUE_HWM_EN
  logic clr_hwm;
  assign clr_hwm = wr_dw2 && cfg_be[1] && cfg_wdata[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_reg <= '0;
    end else if (clr_hwm) begin
      hwm_reg <= count_next;
    end else if (count_next > hwm_reg) begin
      hwm_reg <= count_next;
    end
  end
`else
  assign hwm_reg = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{cfg_wdata[31:17], cfg_wdata[15:2], cfg_be[3], cfg_be[1]};

  assign cfg_rdata    = rdata_reg;
  assign cfg_rd_valid = rd_valid_reg;
  assign irq_req      = irq_req_reg;
  assign queue_count  = count_reg;
  assign queue_hwm    = hwm_reg;

endmodule

// File: tb/tb_frs_queueing_ext_cap.sv
// Directed self-checking bench for frs_queueing_ext_cap (QUEUE_DEPTH=8, int_msg_num=5).
module tb_frs_queueing_ext_cap;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic        cfg_rd = 1'b0;
  logic [1:0]  cfg_dw = 2'd0;
  logic [3:0]  cfg_be = 4'h0;
  logic [31:0] cfg_wdata = 32'h0;
  logic [31:0] cfg_rdata;
  logic        cfg_rd_valid;
  logic [4:0]  int_msg_num = 5'd5;
  logic        frs_msg_valid = 1'b0;
  logic [15:0] frs_msg_rid = 16'h0;
  logic [3:0]  frs_msg_reason = 4'h0;
  logic        irq_req;
  logic [11:0] queue_count;
  logic [11:0] queue_hwm;

  int tests_run = 0;
  int tests_failed = 0;

  frs_queueing_ext_cap #(.QUEUE_DEPTH(8), .CAP_VERSION(4'h1), .NEXT_CAP_PTR(12'h000)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_dw(cfg_dw),
    .cfg_be(cfg_be), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rd_valid(cfg_rd_valid),
    .int_msg_num(int_msg_num), .frs_msg_valid(frs_msg_valid), .frs_msg_rid(frs_msg_rid),
    .frs_msg_reason(frs_msg_reason), .irq_req(irq_req), .queue_count(queue_count),
    .queue_hwm(queue_hwm)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic cfg_read(input logic [1:0] dw, output logic [31:0] data, output logic valid);
    cfg_rd = 1'b1; cfg_dw = dw;
    @(posedge clk); #1 cfg_rd = 1'b0;
    data = cfg_rdata; valid = cfg_rd_valid;
  endtask

  task automatic cfg_write(input logic [1:0] dw, input logic [3:0] be, input logic [31:0] data);
    cfg_wr = 1'b1; cfg_dw = dw; cfg_be = be; cfg_wdata = data;
    @(posedge clk); #1 cfg_wr = 1'b0; cfg_be = 4'h0; cfg_wdata = 32'h0;
  endtask

  task automatic push(input logic [15:0] rid, input logic [3:0] reason);
    frs_msg_valid = 1'b1; frs_msg_rid = rid; frs_msg_reason = reason;
    @(posedge clk); #1 frs_msg_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    do_reset();
    tests_run++;
    if (cfg_rd_valid !== 1'b0 || irq_req !== 1'b0 || queue_count !== 12'd0 || queue_hwm !== 12'd0 || cfg_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b irq=%b count=%0d hwm=%0d rdata=%h, want all 0", cfg_rd_valid, irq_req, queue_count, queue_hwm, cfg_rdata);
    end
    cfg_read(2'd0, d, v);
    tests_run++;
    if (d !== 32'h0001_0021 || v !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_dw0: got %h valid=%b, want 00010021 valid=1", d, v);
    end
    @(posedge clk); #1;
    tests_run++;
    if (cfg_rd_valid !== 1'b0 || cfg_rdata !== 32'h0001_0021) begin
      tests_failed++;
      $display("FAIL rd_valid_drop: got valid=%b rdata=%h, want valid=0 rdata=00010021", cfg_rd_valid, cfg_rdata);
    end
    cfg_read(2'd1, d, v);
    tests_run++;
    if (d !== 32'h0005_0008 || v !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_dw1: got %h valid=%b, want 00050008 valid=1", d, v);
    end
    cfg_read(2'd2, d, v);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL read_dw2_reset: got %h, want 00000000", d);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_fifo_order();
    logic [31:0] d; logic v;
    do_reset();
    push(16'h0100, 4'h1);
    push(16'h0200, 4'h2);
    tests_run++;
    if (queue_count !== 12'd2) begin
      tests_failed++;
      $display("FAIL fifo_count2: got %0d, want 2", queue_count);
    end
    cfg_read(2'd3, d, v);
    tests_run++;
    if (d !== 32'h0001_0100) begin
      tests_failed++;
      $display("FAIL fifo_head1: got %h, want 00010100", d);
    end
    cfg_write(2'd3, 4'hF, 32'hDEAD_BEEF);
    cfg_read(2'd3, d, v);
    tests_run++;
    if (d !== 32'h0002_0200) begin
      tests_failed++;
      $display("FAIL fifo_head2: got %h, want 00020200", d);
    end
    cfg_write(2'd3, 4'h1, 32'h0);
    cfg_read(2'd3, d, v);
    tests_run++;
    if (d !== 32'h0 || queue_count !== 12'd0) begin
      tests_failed++;
      $display("FAIL fifo_empty: got %h count=%0d, want 00000000 count=0", d, queue_count);
    end
    cfg_write(2'd3, 4'hF, 32'h0);
    tests_run++;
    if (queue_count !== 12'd0) begin
      tests_failed++;
      $display("FAIL pop_empty: got count=%0d, want 0", queue_count);
    end
    cfg_write(2'd3, 4'h0, 32'h0);
    $display("[TB] test_fifo_order done");
  endtask

  task automatic test_overflow_and_full();
    logic [31:0] d; logic v;
    logic [11:0] exp_hwm;
    do_reset();
    for (int i = 0; i < 9; i++) push(16'h1000 + 16'(i), 4'(i));
    tests_run++;
    if (queue_count !== 12'd8) begin
      tests_failed++;
      $display("FAIL ovf_count: got %0d, want 8", queue_count);
    end
    cfg_read(2'd2, d, v);
    tests_run++;
    if (d !== 32'h0000_0003) begin
      tests_failed++;
      $display("FAIL ovf_status: got %h, want 00000003", d);
    end
    cfg_write(2'd2, 4'h1, 32'h0000_0002);
    cfg_read(2'd2, d, v);
    tests_run++;
    if (d !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL ovf_clear: got %h, want 00000001", d);
    end
    // Full queue: pop and push together.
    frs_msg_valid = 1'b1; frs_msg_rid = 16'hABCD; frs_msg_reason = 4'h7;
    cfg_write(2'd3, 4'hF, 32'h0);
    frs_msg_valid = 1'b0;
    cfg_read(2'd2, d, v);
    tests_run++;
    if (queue_count !== 12'd8 || d !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL full_push_pop: got count=%0d status=%h, want count=8 status=00000001", queue_count, d);
    end
    cfg_read(2'd3, d, v);
    tests_run++;
    if (d !== 32'h0001_1001) begin
      tests_failed++;
      $display("FAIL full_head: got %h, want 00011001", d);
    end
    for (int i = 0; i < 7; i++) cfg_write(2'd3, 4'h8, 32'h0);
    cfg_read(2'd3, d, v);
    tests_run++;
    if (d !== 32'h0007_ABCD || queue_count !== 12'd1) begin
      tests_failed++;
      $display("FAIL newest_last: got %h count=%0d, want 0007abcd count=1", d, queue_count);
    end
`ifdef FRS_QUEUE_HWM_EN
    exp_hwm = 12'd8;
`else
    exp_hwm = 12'd0;
`endif
    tests_run++;
    if (queue_hwm !== exp_hwm) begin
      tests_failed++;
      $display("FAIL hwm: got %0d, want %0d", queue_hwm, exp_hwm);
    end
    $display("[TB] test_overflow_and_full done");
  endtask

  task automatic test_empty_push_pop();
    logic [31:0] d; logic v;
    do_reset();
    frs_msg_valid = 1'b1; frs_msg_rid = 16'h0042; frs_msg_reason = 4'h3;
    cfg_write(2'd3, 4'hF, 32'h0);
    frs_msg_valid = 1'b0;
    cfg_read(2'd3, d, v);
    tests_run++;
    if (queue_count !== 12'd1 || d !== 32'h0003_0042) begin
      tests_failed++;
      $display("FAIL empty_push_pop: got count=%0d head=%h, want count=1 head=00030042", queue_count, d);
    end
    $display("[TB] test_empty_push_pop done");
  endtask

  task automatic test_irq();
    logic [31:0] d; logic v;
    int pulses;
    do_reset();
    cfg_write(2'd2, 4'h4, 32'h0001_0000);
    cfg_read(2'd2, d, v);
    tests_run++;
    if (d !== 32'h0001_0000 || irq_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_en: got status=%h irq=%b, want 00010000 irq=0", d, irq_req);
    end
    push(16'h0001, 4'h1);
    tests_run++;
    if (irq_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_first: got irq=%b, want 1", irq_req);
    end
    @(posedge clk); #1;
    tests_run++;
    if (irq_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_one_cycle: got irq=%b, want 0", irq_req);
    end
    pulses = 0;
    push(16'h0002, 4'h2);
    if (irq_req === 1'b1) pulses++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (irq_req === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL irq_no_repeat: got %0d pulses, want 0", pulses);
    end
    cfg_write(2'd2, 4'h1, 32'h0000_0001);
    push(16'h0003, 4'h3);
    tests_run++;
    if (irq_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_rearm: got irq=%b, want 1", irq_req);
    end
    // Clear and new event in the same cycle: Received stays set, no new pulse.
    frs_msg_valid = 1'b1; frs_msg_rid = 16'h0004; frs_msg_reason = 4'h4;
    cfg_write(2'd2, 4'h1, 32'h0000_0001);
    frs_msg_valid = 1'b0;
    pulses = (irq_req === 1'b1) ? 1 : 0;
    cfg_read(2'd2, d, v);
    tests_run++;
    if (d !== 32'h0001_0001 || pulses != 0) begin
      tests_failed++;
      $display("FAIL set_wins: got status=%h pulses=%0d, want 00010001 pulses=0", d, pulses);
    end
    $display("[TB] test_irq done");
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic v;
    do_reset();
    cfg_write(2'd2, 4'h4, 32'h0001_0000);
    push(16'h0011, 4'h1);
    push(16'h0022, 4'h2);
    frs_msg_valid = 1'b1; frs_msg_rid = 16'h0033; frs_msg_reason = 4'h3;
    cfg_rd = 1'b1; cfg_dw = 2'd3;
    @(posedge clk); #1;
    frs_msg_valid = 1'b0; cfg_rd = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (queue_count !== 12'd0 || irq_req !== 1'b0 || cfg_rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got count=%0d irq=%b valid=%b, want 0 0 0", queue_count, irq_req, cfg_rd_valid);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    cfg_read(2'd3, d, v);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_dw3: got %h, want 00000000", d);
    end
    cfg_read(2'd2, d, v);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_status: got %h, want 00000000", d);
    end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_overflow_and_full();
    test_empty_push_pop();
    test_irq();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
